// File: rtl/drive_pkg.sv
// Shared encodings for the drive mode sequencer: run/moving states, modes,
// power FSM states and source-mux indices.
package drive_pkg;

    localparam logic [1:0] ST_NSTART = 2'b00;
    localparam logic [1:0] ST_START  = 2'b01;
    localparam logic [1:0] ST_MOVING = 2'b10;

    localparam logic [3:0] MV_NONE  = 4'b0000;
    localparam logic [3:0] MV_FWD   = 4'b0001;
    localparam logic [3:0] MV_BACK  = 4'b0010;
    localparam logic [3:0] MV_LEFT  = 4'b0100;
    localparam logic [3:0] MV_RIGHT = 4'b1000;

    // Mode encodings double as the source-mux index; MODE_KEEP selects manual.
    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_SEMI   = 2'b01;
    localparam logic [1:0] MODE_AUTO   = 2'b10;
    localparam logic [1:0] MODE_KEEP   = 2'b11;

    typedef enum logic {
        P_OFF = 1'b0,
        P_ON  = 1'b1
    } pwr_state_e;

endpackage

// File: rtl/turn_light_blinker.sv
// Turn-light blinker: phase toggles every BLINK_HALF_CYC cycles while either
// raw light is on; both off restarts the pattern in the lit phase.
module turn_light_blinker #(
    parameter int BLINK_HALF_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_l,
    input  logic raw_r,
    output logic l,
    output logic r
);
    localparam int CW = $clog2(BLINK_HALF_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (raw_l | raw_r) begin
            if (cnt_q >= CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign l = raw_l & ~phase_q;
    assign r = raw_r & ~phase_q;

endmodule

// File: rtl/drive_mode_sequencer.sv
// Registered owner of car power/mode/run state; muxes the manual/semi/auto next-state
// blocks by mode. Optional mileage counter is built when MILEAGE_EN is defined.
module drive_mode_sequencer
    import drive_pkg::*;
#(
    parameter int PWR_HOLD_CYC   = 100_000_000,
    parameter int IDLE_OFF_CYC   = 1_000_000_000,
    parameter int BLINK_HALF_CYC = 50_000_000,
    parameter int MILE_TICK_CYC  = 10_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        power_btn,
    input  logic [1:0]  mode_sel,
    input  logic [1:0]  m_next_state,
    input  logic [3:0]  m_next_move,
    input  logic        m_power,
    input  logic        m_tl,
    input  logic        m_tr,
    input  logic [1:0]  s_next_state,
    input  logic [3:0]  s_next_move,
    input  logic        s_power,
    input  logic        s_tl,
    input  logic        s_tr,
    input  logic [1:0]  a_next_state,
    input  logic [3:0]  a_next_move,
    input  logic        a_power,
    input  logic        a_tl,
    input  logic        a_tr,
    output logic        power,
    output logic [1:0]  global_state,
    output logic [1:0]  state,
    output logic [3:0]  moving_state,
    output logic        turn_left_light,
    output logic        turn_right_light,
    output logic        mode_locked,
    output logic [15:0] mileage
);
    localparam int HW = $clog2(PWR_HOLD_CYC + 1);
    localparam int IW = $clog2(IDLE_OFF_CYC + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(PWR_HOLD_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(PWR_HOLD_CYC);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_OFF_CYC - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_OFF_CYC);

    logic          btn_s1_q, btn_s2_q, btn_prev_q;
    pwr_state_e    pwr_q, pwr_d;
    logic [1:0]    gstate_q, gstate_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    move_q, move_d;
    logic          armed_q, armed_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [IW-1:0] idle_q, idle_d;

    logic [1:0] sel_state;
    logic [3:0] sel_move;
    logic       sel_power, sel_tl, sel_tr;
    logic       btn_rise, is_idle, held, off_cause, mode_req, commit;

    always_comb begin
        case (gstate_q)
            MODE_SEMI: {sel_state, sel_move, sel_power, sel_tl, sel_tr} =
                       {s_next_state, s_next_move, s_power, s_tl, s_tr};
            MODE_AUTO: {sel_state, sel_move, sel_power, sel_tl, sel_tr} =
                       {a_next_state, a_next_move, a_power, a_tl, a_tr};
            default:   {sel_state, sel_move, sel_power, sel_tl, sel_tr} =
                       {m_next_state, m_next_move, m_power, m_tl, m_tr};
        endcase
    end

    always_comb begin
        btn_rise  = btn_s2_q & ~btn_prev_q;
        is_idle   = (pwr_q == P_ON) && (state_q == ST_NSTART) && (move_q == MV_NONE);
        // The power-on press only counts toward hold-off after one release.
        held      = (pwr_q == P_ON) && armed_q && btn_s2_q;
        off_cause = (pwr_q == P_ON) &&
                    ((held && hold_q >= HOLD_LAST) || !sel_power ||
                     (is_idle && idle_q >= IDLE_LAST));
        mode_req  = (mode_sel != MODE_KEEP) && (mode_sel != gstate_q);
        commit    = mode_req && is_idle && !off_cause;

        pwr_d    = pwr_q;
        gstate_d = gstate_q;
        state_d  = ST_NSTART;
        move_d   = MV_NONE;
        armed_d  = 1'b0;
        hold_d   = '0;
        idle_d   = '0;

        if (pwr_q == P_OFF) begin
            if (btn_rise) pwr_d = P_ON;
        end else if (off_cause) begin
            pwr_d = P_OFF;
        end else begin
            armed_d = armed_q | ~btn_s2_q;
            if (held) hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
            if (commit) begin
                gstate_d = mode_sel;
            end else begin
                state_d = sel_state;
                move_d  = sel_move;
                if (is_idle) idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            pwr_q      <= P_OFF;
            gstate_q   <= MODE_MANUAL;
            state_q    <= ST_NSTART;
            move_q     <= MV_NONE;
            armed_q    <= 1'b0;
            hold_q     <= '0;
            idle_q     <= '0;
        end else begin
            btn_s1_q   <= power_btn;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            pwr_q      <= pwr_d;
            gstate_q   <= gstate_d;
            state_q    <= state_d;
            move_q     <= move_d;
            armed_q    <= armed_d;
            hold_q     <= hold_d;
            idle_q     <= idle_d;
        end
    end

    turn_light_blinker #(.BLINK_HALF_CYC(BLINK_HALF_CYC)) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_l (sel_tl & (pwr_q == P_ON)),
        .raw_r (sel_tr & (pwr_q == P_ON)),
        .l     (turn_left_light),
        .r     (turn_right_light)
    );

`ifdef MILEAGE_EN
    localparam int TW = $clog2(MILE_TICK_CYC + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(MILE_TICK_CYC - 1);

    logic [TW-1:0] tick_q, tick_d;
    logic [15:0]   mile_q, mile_d;

    always_comb begin
        tick_d = tick_q;
        mile_d = mile_q;
        if (pwr_q == P_OFF && btn_rise) begin
            tick_d = '0;
            mile_d = '0;
        end else if (pwr_q == P_ON && move_q != MV_NONE) begin
            if (tick_q >= TICK_LAST) begin
                tick_d = '0;
                mile_d = (mile_q == 16'hFFFF) ? mile_q : mile_q + 16'd1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
            mile_q <= '0;
        end else begin
            tick_q <= tick_d;
            mile_q <= mile_d;
        end
    end

    assign mileage = mile_q;
`else
    assign mileage = 16'h0;
`endif

    assign power        = (pwr_q == P_ON);
    assign global_state = gstate_q;
    assign state        = state_q;
    assign moving_state = move_q;
    // Reset gating keeps the refusal flag low while the block is held in reset.
    assign mode_locked  = rst_n & mode_req & ~commit;

endmodule

// File: tb/tb_drive_mode_sequencer.sv
// Directed bench for drive_mode_sequencer with short timer parameters.
// Mileage check is built only when MILEAGE_EN is defined.
module tb_drive_mode_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        power_btn;
    logic [1:0]  mode_sel;
    logic [1:0]  m_next_state, s_next_state, a_next_state;
    logic [3:0]  m_next_move, s_next_move, a_next_move;
    logic        m_power, s_power, a_power;
    logic        m_tl, m_tr, s_tl, s_tr, a_tl, a_tr;
    logic        power;
    logic [1:0]  global_state, state;
    logic [3:0]  moving_state;
    logic        turn_left_light, turn_right_light, mode_locked;
    logic [15:0] mileage;

    int checks = 0;
    int errors = 0;

    drive_mode_sequencer #(
        .PWR_HOLD_CYC(4), .IDLE_OFF_CYC(8), .BLINK_HALF_CYC(2), .MILE_TICK_CYC(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .power_btn(power_btn), .mode_sel(mode_sel),
        .m_next_state(m_next_state), .m_next_move(m_next_move), .m_power(m_power),
        .m_tl(m_tl), .m_tr(m_tr),
        .s_next_state(s_next_state), .s_next_move(s_next_move), .s_power(s_power),
        .s_tl(s_tl), .s_tr(s_tr),
        .a_next_state(a_next_state), .a_next_move(a_next_move), .a_power(a_power),
        .a_tl(a_tl), .a_tr(a_tr),
        .power(power), .global_state(global_state), .state(state),
        .moving_state(moving_state), .turn_left_light(turn_left_light),
        .turn_right_light(turn_right_light), .mode_locked(mode_locked), .mileage(mileage)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pwr_on();
        power_btn = 1'b1;
        step(1);
        power_btn = 1'b0;
        step(1);
        chk("pwr_on_sync", power, 0);
        step(1);
        chk("pwr_on", power, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        power_btn = 1'b0;
        mode_sel = 2'b11;
        m_next_state = 2'b01; m_next_move = 4'b0000; m_power = 1'b1; m_tl = 1'b0; m_tr = 1'b0;
        s_next_state = 2'b01; s_next_move = 4'b0000; s_power = 1'b1; s_tl = 1'b0; s_tr = 1'b0;
        a_next_state = 2'b10; a_next_move = 4'b0100; a_power = 1'b1; a_tl = 1'b0; a_tr = 1'b0;
        #12;
        chk("rst_power", power, 0);
        chk("rst_gstate", global_state, 0);
        chk("rst_state", state, 0);
        chk("rst_move", moving_state, 0);
        chk("rst_lock", mode_locked, 0);
        chk("rst_mile", mileage, 0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // power-on pulse, short hold keeps power, 4-cycle hold turns off
        pwr_on();
        step(1);
        chk("state_start", state, 2'b01);
        power_btn = 1'b1; step(3); power_btn = 1'b0; step(4);
        chk("hold3_on", power, 1);
        power_btn = 1'b1; step(4); power_btn = 1'b0; step(1);
        chk("hold_edge_on", power, 1);
        step(1);
        chk("hold4_off", power, 0);
        chk("hold4_state", state, 0);
        step(3);

        // mode change refused while moving, committed once NSTART registered
        pwr_on();
        m_next_state = 2'b10; m_next_move = 4'b0001;
        step(1);
        chk("moving", state, 2'b10);
        mode_sel = 2'b10; #1;
        chk("lock_moving", mode_locked, 1);
        step(1);
        chk("lock_gstate", global_state, 0);
        m_next_state = 2'b00; m_next_move = 4'b0000;
        step(1);
        chk("unlock", mode_locked, 0);
        chk("pre_commit_gs", global_state, 0);
        step(1);
        chk("commit_gs", global_state, 2'b10);
        chk("commit_state", state, 0);
        mode_sel = 2'b11;
        step(1);
        chk("auto_state", state, 2'b10);
        chk("auto_move", moving_state, 4'b0100);
        a_next_state = 2'b00; a_next_move = 4'b0000; mode_sel = 2'b00;
        step(1);
        step(1);
        chk("back_manual", global_state, 0);
        mode_sel = 2'b11; m_next_state = 2'b01;
        step(1);

        // idle auto-off after 8 idle cycles
        m_next_state = 2'b00;
        step(1);
        step(7);
        chk("idle7_on", power, 1);
        step(1);
        chk("idle8_off", power, 0);
        m_next_state = 2'b01;
        step(2);
        pwr_on();
        step(1);
        m_next_state = 2'b00;
        step(1);
        step(4);
        m_next_state = 2'b01;
        step(1);
        m_next_state = 2'b00;
        step(1);
        step(7);
        chk("idle_clear_on", power, 1);
        step(1);
        chk("idle_clear_off", power, 0);
        m_next_state = 2'b01;
        step(2);

        // blink pattern 1,1,0,0,1,1 then phase reset
        pwr_on();
        step(1);
        m_tl = 1'b1; #1;
        chk("blink0", turn_left_light, 1);
        step(1); chk("blink1", turn_left_light, 1);
        step(1); chk("blink2", turn_left_light, 0);
        step(1); chk("blink3", turn_left_light, 0);
        step(1); chk("blink4", turn_left_light, 1);
        step(1); chk("blink5", turn_left_light, 1);
        chk("blink_r", turn_right_light, 0);
        m_tl = 1'b0;
        step(1); chk("blink_off", turn_left_light, 0);
        m_tl = 1'b1; #1;
        chk("blink_re0", turn_left_light, 1);
        step(1); chk("blink_re1", turn_left_light, 1);
        step(1); chk("blink_re2", turn_left_light, 0);
        m_tl = 1'b0;

`ifdef MILEAGE_EN
        m_next_state = 2'b10; m_next_move = 4'b0001;
        step(1);
        step(9);
        chk("mileage3", mileage, 16'd3);
        m_next_state = 2'b01; m_next_move = 4'b0000;
        step(1);
`else
        chk("mileage_tied", mileage, 0);
`endif

        // power-off source beats a mode commit in the same cycle
        m_next_state = 2'b00;
        step(1);
        mode_sel = 2'b01; m_power = 1'b0;
        step(1);
        chk("pwroff_prec", power, 0);
        chk("pwroff_gs", global_state, 0);
        chk("off_locked", mode_locked, 1);
        mode_sel = 2'b11; m_power = 1'b1; m_next_state = 2'b01;
        step(2);

        // asynchronous reset while moving
        pwr_on();
        m_next_state = 2'b10; m_next_move = 4'b0001; m_tl = 1'b1;
        step(1);
        chk("pre_rst_state", state, 2'b10);
        #3; rst_n = 1'b0; #1;
        chk("arst_power", power, 0);
        chk("arst_state", state, 0);
        chk("arst_move", moving_state, 0);
        chk("arst_light", turn_left_light, 0);
        step(2);
        chk("arst_hold", state, 0);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_power", power, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
